// File: rtl/jtag_user_dr_bridge.sv
// JTAG user data register stage. Each scanned command becomes one read or
// write on a valid/ready register bus. TCK is oversampled in the clk_p domain.
module jtag_user_dr_bridge #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk_p,
    input  logic              rst_top,
    input  logic              tck_i,
    input  logic              tdi_i,
    input  logic              sel_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    input  logic              test_logic_reset_i,
    output logic              tdo_o,
    output logic              req_valid_o,
    output logic              req_write_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i
);
    localparam int N    = 2 + ADDR_W + DATA_W;
    localparam int NSIG = 7;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] STAT_IDLE  = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_DONE  = 2'b10;
    localparam logic [1:0] STAT_ERROR = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    logic [NSIG-1:0]   pins;
    logic [NSIG-1:0]   sync_q [SYNC_STAGES];
    logic [NSIG-1:0]   synced;
    logic              tck_s, tdi_s, sel_s, capture_s, shift_s, update_s, tlr_s;
    logic              tck_d, tck_rise, tck_fall;
    logic [N-1:0]      sr;
    logic [1:0]        status;
    logic [1:0]        done_status;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rdata;
    state_t            state;
    logic [7:0]        timer;
    logic              dr_cycle, update_pulse, cmd_rw;
    logic [1:0]        op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    assign pins = {tck_i, tdi_i, sel_i, capture_dr_i, shift_dr_i, update_dr_i, test_logic_reset_i};
    assign synced = sync_q[SYNC_STAGES-1];
    assign {tck_s, tdi_s, sel_s, capture_s, shift_s, update_s, tlr_s} = synced;

    // Edge pulses are registered, so they lag the synced TCK by one more cycle.
    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            tck_d    <= 1'b0;
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            tck_d    <= tck_s;
            tck_rise <= tck_s & ~tck_d;
            tck_fall <= ~tck_s & tck_d;
        end
    end

    assign dr_cycle     = tck_rise & sel_s;
    assign update_pulse = dr_cycle & update_s;
    assign op           = sr[N-1:N-2];
    assign cmd_addr     = sr[N-3:DATA_W];
    assign cmd_data     = sr[DATA_W-1:0];
    assign cmd_rw       = (op == OP_READ) || (op == OP_WRITE);
    assign done_status  = (status == STAT_ERROR) ? STAT_ERROR : STAT_DONE;

    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) begin
            sr    <= '0;
            tdo_o <= 1'b0;
        end else if (tlr_s) begin
            sr    <= '0;
            tdo_o <= 1'b0;
        end else begin
            if (dr_cycle && capture_s) begin
                sr <= {status, last_addr, rdata};
            end else if (dr_cycle && shift_s) begin
                sr <= {tdi_s, sr[N-1:1]};
            end
            if (tck_fall) begin
                tdo_o <= sr[0];
            end
        end
    end

    // An error status survives later completions until explicitly cleared.
    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) begin
            state       <= IDLE;
            status      <= STAT_IDLE;
            last_addr   <= '0;
            rdata       <= '0;
            timer       <= '0;
            req_valid_o <= 1'b0;
            req_write_o <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (update_pulse && cmd_rw) begin
                        last_addr   <= cmd_addr;
                        req_addr_o  <= cmd_addr;
                        req_wdata_o <= cmd_data;
                        req_write_o <= (op == OP_WRITE);
                        req_valid_o <= 1'b1;
                        if (status != STAT_ERROR) status <= STAT_BUSY;
                        state <= REQ;
                    end else if (update_pulse && op == OP_CLEAR) begin
                        status <= STAT_IDLE;
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        req_valid_o <= 1'b0;
                        if (req_write_o) begin
                            status <= done_status;
                            state  <= IDLE;
                        end else begin
                            timer <= '0;
                            state <= WAIT;
                        end
                    end
                    if (update_pulse && cmd_rw) status <= STAT_ERROR;
                end
                WAIT: begin
                    if (rsp_valid_i) begin
                        rdata  <= rsp_rdata_i;
                        status <= done_status;
                        state  <= IDLE;
                    end else if (timer == TIMEOUT_CNT) begin
                        status <= STAT_ERROR;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                    if (update_pulse && cmd_rw) status <= STAT_ERROR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
